// File: rtl/compute_b_seq_pkg.sv
// Shared definitions for the b-offset stage: FSM encoding, internal width
// derivation and the edge-state mode decode.
package compute_b_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } b_state_e;

    // Signed working width: wide enough for (SR-SL) +/- 2(A-B) without overflow.
    function automatic int calc_w(input int sw, input int aw);
        return ((sw > aw) ? sw : aw) + 3;
    endfunction

    function automatic int calc_n(input int sw, input int aw, input int frac_w);
        return calc_w(sw, aw) + frac_w;
    endfunction

    function automatic logic mode_decode(input logic [31:0] st, input logic [31:0] mask);
        return |(st & mask);
    endfunction

endpackage

// File: rtl/compute_b_seq_if.sv
// Operand/result handshake bundle for compute_b_seq; slave is the block side.
interface compute_b_seq_if #(
    parameter int SW      = 11,
    parameter int AW      = 10,
    parameter int STATE_W = 4,
    parameter int RES_W   = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] state;
    logic [SW-1:0]      SL;
    logic [SW-1:0]      SR;
    logic [AW-1:0]      A;
    logic [AW-1:0]      B;
    logic               out_valid;
    logic               out_ready;
    logic [RES_W-1:0]   result_b;
    logic               bdivbyzero;
    logic               bsat;

    modport master (
        output in_valid, state, SL, SR, A, B, out_ready,
        input  in_ready, out_valid, result_b, bdivbyzero, bsat
    );

    modport slave (
        input  in_valid, state, SL, SR, A, B, out_ready,
        output in_ready, out_valid, result_b, bdivbyzero, bsat
    );
endinterface

// File: rtl/compute_b_seq_udiv.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
// done is high during the cycle in which the final bit is produced.
module seq_udiv #(
    parameter int NW = 30,
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [NW-1:0] quotient
);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    logic          busy_r;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] rem_r;
    logic [NW-1:0] quo_r;
    logic [DW-1:0] dvs_r;
    logic [DW:0]   rem_shift_s;
    logic          fits_s;
    logic [DW-1:0] rem_next_s;

    // Trial subtraction for the current quotient bit.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[NW-1]};
        fits_s      = (rem_shift_s >= {1'b0, dvs_r});
        if (fits_s) begin
            rem_next_s = DW'(rem_shift_s - {1'b0, dvs_r});
        end else begin
            rem_next_s = rem_shift_s[DW-1:0];
        end
    end

    // Dividend shifts out of quo_r while quotient bits shift in.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            dvs_r  <= '0;
        end else if (start) begin
            busy_r <= 1'b1;
            cnt_r  <= CW'(NW - 1);
            rem_r  <= '0;
            quo_r  <= dividend;
            dvs_r  <= divisor;
        end else if (busy_r) begin
            rem_r <= rem_next_s;
            quo_r <= {quo_r[NW-2:0], fits_s};
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(0)) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign done     = busy_r && (cnt_r == CW'(0));
    assign quotient = quo_r;

endmodule

// File: rtl/compute_b_seq.sv
// Edge-offset b stage: b = (SR-SL +/- 2(A-B)) / (2(A-B)) in signed fixed point,
// with an internal iterative divider and valid/ready on both sides.
module compute_b_seq
    import compute_b_seq_pkg::*;
#(
    parameter int                 SW        = 11,
    parameter int                 AW        = 10,
    parameter int                 STATE_W   = 4,
    parameter logic [STATE_W-1:0] MODE_MASK = STATE_W'(4'b1010),
    parameter int                 FRAC_W    = 16,
    parameter int                 RES_W     = 32
) (
    input logic              clk,
    input logic              rst,
    compute_b_seq_if.slave   bus
);
    localparam int W  = calc_w(SW, AW);
    localparam int N  = calc_n(SW, AW, FRAC_W);
    localparam int EW = ((N > RES_W) ? N : RES_W) + 1;

    localparam logic [EW-1:0]    POS_MAX = {{(EW-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
    localparam logic [EW-1:0]    NEG_MAG = {{(EW-RES_W){1'b0}}, 1'b1, {(RES_W-1){1'b0}}};
    localparam logic [RES_W-1:0] SAT_POS = {1'b0, {(RES_W-1){1'b1}}};
    localparam logic [RES_W-1:0] SAT_NEG = {1'b1, {(RES_W-1){1'b0}}};

    b_state_e           state_r;
    b_state_e           state_nx_s;
    logic [STATE_W-1:0] op_state_r;
    logic [SW-1:0]      sl_r;
    logic [SW-1:0]      sr_r;
    logic [AW-1:0]      a_r;
    logic [AW-1:0]      b_r;
    logic               neg_r;
    logic               dbz_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [RES_W-1:0]   result_r;
    logic               bdivbyzero_r;
    logic               bsat_r;

    logic signed [W-1:0] sl_ext_s;
    logic signed [W-1:0] sr_ext_s;
    logic signed [W-1:0] a_ext_s;
    logic signed [W-1:0] b_ext_s;
    logic signed [W-1:0] diff_s;
    logic signed [W-1:0] den_s;
    logic signed [W-1:0] num_s;
    logic                mode_s;
    logic [W-1:0]        abs_num_s;
    logic [W-1:0]        abs_den_s;
    logic [N-1:0]        dividend_s;
    logic                dbz_s;
    logic                div_start_s;
    logic                div_done_s;
    logic [N-1:0]        div_quotient_s;
    logic [EW-1:0]       q_ext_s;
    logic [RES_W-1:0]    fix_res_s;
    logic                fix_sat_s;

    // Operand arithmetic evaluated while in PREP, from the captured operand set.
    always_comb begin
        sl_ext_s  = $signed({{(W-SW){1'b0}}, sl_r});
        sr_ext_s  = $signed({{(W-SW){1'b0}}, sr_r});
        a_ext_s   = $signed({{(W-AW){1'b0}}, a_r});
        b_ext_s   = $signed({{(W-AW){1'b0}}, b_r});
        diff_s    = sr_ext_s - sl_ext_s;
        den_s     = (a_ext_s - b_ext_s) <<< 1;
        mode_s    = mode_decode(32'(op_state_r), 32'(MODE_MASK));
        if (mode_s) begin
            num_s = diff_s + den_s;
        end else begin
            num_s = diff_s - den_s;
        end
        if (num_s[W-1]) begin
            abs_num_s = W'(-num_s);
        end else begin
            abs_num_s = W'(num_s);
        end
        if (den_s[W-1]) begin
            abs_den_s = W'(-den_s);
        end else begin
            abs_den_s = W'(den_s);
        end
        dividend_s = {abs_num_s, {FRAC_W{1'b0}}};
        dbz_s      = (den_s == {W{1'b0}});
    end

    seq_udiv #(
        .NW (N),
        .DW (W)
    ) u_udiv (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (dividend_s),
        .divisor  (abs_den_s),
        .done     (div_done_s),
        .quotient (div_quotient_s)
    );

    // Next-state decode for the one-op-in-flight handshake sequence.
    always_comb begin
        state_nx_s  = state_r;
        div_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nx_s = ST_PREP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PREP: begin
                state_nx_s  = ST_DIV;
                div_start_s = 1'b1;
            end
            ST_DIV: begin
                if (div_done_s) begin
                    state_nx_s = ST_FIX;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_FIX: begin
                state_nx_s = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sign application and saturation of the unsigned quotient; dbz forces zero.
    always_comb begin
        q_ext_s   = EW'(div_quotient_s);
        fix_res_s = '0;
        fix_sat_s = 1'b0;
        if (dbz_r) begin
            fix_res_s = '0;
            fix_sat_s = 1'b0;
        end else if (neg_r) begin
            if (q_ext_s > NEG_MAG) begin
                fix_res_s = SAT_NEG;
                fix_sat_s = 1'b1;
            end else begin
                fix_res_s = RES_W'(EW'(0) - q_ext_s);
                fix_sat_s = 1'b0;
            end
        end else begin
            if (q_ext_s > POS_MAX) begin
                fix_res_s = SAT_POS;
                fix_sat_s = 1'b1;
            end else begin
                fix_res_s = RES_W'(q_ext_s);
                fix_sat_s = 1'b0;
            end
        end
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
        end
    end

    // Operand capture, PREP sign/dbz latch and result/flag update on FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_state_r   <= '0;
            sl_r         <= '0;
            sr_r         <= '0;
            a_r          <= '0;
            b_r          <= '0;
            neg_r        <= 1'b0;
            dbz_r        <= 1'b0;
            result_r     <= '0;
            bdivbyzero_r <= 1'b0;
            bsat_r       <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && bus.in_valid) begin
                op_state_r <= bus.state;
                sl_r       <= bus.SL;
                sr_r       <= bus.SR;
                a_r        <= bus.A;
                b_r        <= bus.B;
            end
            if (state_r == ST_PREP) begin
                neg_r <= num_s[W-1] ^ den_s[W-1];
                dbz_r <= dbz_s;
            end
            if (state_r == ST_FIX) begin
                result_r     <= fix_res_s;
                bdivbyzero_r <= dbz_r;
                bsat_r       <= fix_sat_s;
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.result_b   = result_r;
    assign bus.bdivbyzero = bdivbyzero_r;
    assign bus.bsat       = bsat_r;

endmodule

// File: tb/tb_compute_b_seq.sv
// Self-checking bench for compute_b_seq: directed cases, random operands
// against an arithmetic reference, a 20-bit saturating instance and reset abort.
module tb_compute_b_seq;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    compute_b_seq_if #(.RES_W(32)) bus0 ();
    compute_b_seq_if #(.RES_W(20)) bus1 ();

    compute_b_seq #(.RES_W(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    compute_b_seq #(.RES_W(20)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // b = (SR-SL +/- 2(A-B)) / 2(A-B) in Q.16, truncated toward zero, saturated to resw bits.
    function automatic void ref_b(input logic [3:0] st, input int sr, input int sl,
                                  input int a, input int b, input int resw,
                                  output longint res, output logic dbz, output logic sat);
        longint num, den, q, maxp, minn, an, ad;
        logic [3:0] msk;
        msk = st & 4'b1010;
        den = 2 * (longint'(a) - longint'(b));
        num = (msk != 4'b0000) ? (longint'(sr) - sl) + den : (longint'(sr) - sl) - den;
        res = 0;
        dbz = 1'b0;
        sat = 1'b0;
        if (den == 0) begin
            dbz = 1'b1;
        end else begin
            an = (num < 0) ? -num : num;
            ad = (den < 0) ? -den : den;
            q  = (an * 65536) / ad;
            if ((num < 0) != (den < 0)) q = -q;
            maxp = (longint'(1) << (resw - 1)) - 1;
            minn = -(maxp + 1);
            if (q > maxp) begin
                q = maxp;
                sat = 1'b1;
            end else if (q < minn) begin
                q = minn;
                sat = 1'b1;
            end
            res = q;
        end
    endfunction

    task automatic run0(input logic [3:0] st, input int sr, input int sl, input int a,
                        input int b, input int hold, input string tag);
        longint      er;
        logic        edbz, esat;
        logic [31:0] exp_res;
        int          edges;
        ref_b(st, sr, sl, a, b, 32, er, edbz, esat);
        exp_res = er[31:0];
        @(negedge clk);
        check({tag, " in_ready idle"}, {63'd0, bus0.in_ready}, 64'd1);
        bus0.in_valid = 1'b1;
        bus0.state    = st;
        bus0.SR       = sr[10:0];
        bus0.SL       = sl[10:0];
        bus0.A        = a[9:0];
        bus0.B        = b[9:0];
        @(posedge clk);
        #1;
        // keep offering garbage while busy: it must be ignored
        bus0.state = 4'($urandom);
        bus0.SR    = 11'($urandom);
        bus0.SL    = 11'($urandom);
        bus0.A     = 10'($urandom);
        bus0.B     = 10'($urandom);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus0.out_valid && edges < 60);
        check({tag, " latency"}, 64'(edges), 64'd32);
        check({tag, " result_b"}, {32'd0, bus0.result_b}, {32'd0, exp_res});
        check({tag, " bdivbyzero"}, {63'd0, bus0.bdivbyzero}, {63'd0, edbz});
        check({tag, " bsat"}, {63'd0, bus0.bsat}, {63'd0, esat});
        check({tag, " in_ready busy"}, {63'd0, bus0.in_ready}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, {63'd0, bus0.out_valid}, 64'd1);
            check({tag, " hold result"}, {32'd0, bus0.result_b}, {32'd0, exp_res});
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
        check({tag, " valid drop"}, {63'd0, bus0.out_valid}, 64'd0);
        check({tag, " ready back"}, {63'd0, bus0.in_ready}, 64'd1);
    endtask

    initial begin
        longint      er;
        logic        edbz, esat;
        logic [19:0] exp20;
        int          edges;
        logic [3:0]  rst_st;
        int          rsr, rsl, ra, rb;
        logic        seen;

        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.state = 4'd0;
        bus0.SR = 11'd0; bus0.SL = 11'd0; bus0.A = 10'd0; bus0.B = 10'd0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.state = 4'd0;
        bus1.SR = 11'd0; bus1.SL = 11'd0; bus1.A = 10'd0; bus1.B = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", {63'd0, bus0.in_ready}, 64'd1);
        check("rst out_valid", {63'd0, bus0.out_valid}, 64'd0);
        check("rst result", {32'd0, bus0.result_b}, 64'd0);
        check("rst flags", {62'd0, bus0.bdivbyzero, bus0.bsat}, 64'd0);
        rst = 1'b0;

        run0(4'b1000, 600, 400, 300, 200, 2, "t1 plus");
        run0(4'b0001, 600, 400, 300, 200, 0, "t2 zero");
        run0(4'b0001, 400, 600, 300, 250, 1, "t3 neg3");
        run0(4'b0010, 401, 400, 201, 200, 0, "t4 1p5");
        run0(4'b0000, 401, 400, 201, 200, 0, "t4 m0p5");
        run0(4'b1111, 77, 1900, 123, 123, 3, "t5 dbz");
        run0(4'b0101, 2047, 0, 0, 1023, 0, "edge negden");

        for (int k = 0; k < 30; k++) begin
            rst_st = 4'($urandom_range(15, 0));
            rsr = int'($urandom_range(2047, 0));
            rsl = int'($urandom_range(2047, 0));
            ra  = int'($urandom_range(1023, 0));
            rb  = ($urandom_range(7, 0) == 0) ? ra : int'($urandom_range(1023, 0));
            run0(rst_st, rsr, rsl, ra, rb, int'($urandom_range(2, 0)), "rand");
        end

        // 20-bit result: saturation, stable hold with out_ready low
        ref_b(4'b1000, 2047, 0, 1, 0, 20, er, edbz, esat);
        exp20 = er[19:0];
        @(negedge clk);
        bus1.in_valid = 1'b1; bus1.state = 4'b1000;
        bus1.SR = 11'd2047; bus1.SL = 11'd0; bus1.A = 10'd1; bus1.B = 10'd0;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus1.out_valid && edges < 60);
        check("t6 latency", 64'(edges), 64'd32);
        check("t6 result", {44'd0, bus1.result_b}, {44'd0, exp20});
        check("t6 bsat", {63'd0, bus1.bsat}, {63'd0, esat});
        check("t6 dbz", {63'd0, bus1.bdivbyzero}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t6 hold valid", {63'd0, bus1.out_valid}, 64'd1);
            check("t6 hold result", {44'd0, bus1.result_b}, {44'd0, exp20});
            check("t6 hold in_ready", {63'd0, bus1.in_ready}, 64'd0);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        check("t6 release", {63'd0, bus1.out_valid}, 64'd0);

        // reset during DIV aborts the operation
        @(negedge clk);
        bus1.in_valid = 1'b1; bus1.state = 4'b0010;
        bus1.SR = 11'd401; bus1.SL = 11'd400; bus1.A = 10'd201; bus1.B = 10'd200;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus1.out_valid) seen = 1'b1;
        end
        check("abort no valid", {63'd0, seen}, 64'd0);
        check("abort in_ready", {63'd0, bus1.in_ready}, 64'd1);
        check("abort result", {44'd0, bus1.result_b}, 64'd0);
        check("abort bsat", {63'd0, bus1.bsat}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
